// File: rtl/axi_rd_arbiter.sv
// Two-requester arbiter for the core's single AXI read channel (AR/R), one burst in flight.
// Optional round-robin tie-break when AXI_RD_ARB_RR_EN is defined; fixed priority (m1 wins) otherwise.
module axi_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              global_reset,
    // m0: icache refill
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [7:0]        m0_len,
    input  logic [2:0]        m0_size,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_rlast,
    input  logic              m0_rready,
    // m1: dcache refill / uncached load
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [7:0]        m1_len,
    input  logic [2:0]        m1_size,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_rlast,
    input  logic              m1_rready,
    // AXI AR
    output logic [ID_W-1:0]   arid,
    output logic [ADDR_W-1:0] araddr,
    output logic [7:0]        arlen,
    output logic [2:0]        arsize,
    output logic [1:0]        arburst,
    output logic              arlock,
    output logic [3:0]        arcache,
    output logic [2:0]        arprot,
    output logic              arvalid,
    input  logic              arready,
    // AXI R
    input  logic [ID_W-1:0]   rid,
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        rresp,
    input  logic              rlast,
    input  logic              rvalid,
    output logic              rready
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
    } ar_req_t;

    state_t  state, state_nxt;
    logic    owner;
    logic    win;
    ar_req_t ar_q;
    logic    any_req;
    logic    ar_hs;
    logic    r_done;

    assign any_req = m0_req | m1_req;
    assign ar_hs   = (state == ADDR) & arready;
    assign r_done  = (state == DATA) & rvalid & rready & rlast;

`ifdef AXI_RD_ARB_RR_EN
    logic last_owner;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        win = m1_req;
        if (m0_req && m1_req)
            win = ~last_owner;
    end

    always_ff @(posedge aclk) begin
        if (global_reset)
            last_owner <= 1'b1;
        else if (ar_hs)
            last_owner <= owner;
    end
`else
    assign win = m1_req;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ADDR;
            ADDR:    if (arready) state_nxt = DATA;
            DATA:    if (r_done)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // AR fields come only from this snapshot, so they stay put while arready is low.
    always_ff @(posedge aclk) begin
        if (global_reset) begin
            state <= IDLE;
            owner <= 1'b0;
            ar_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) begin
                owner <= win;
                ar_q  <= win ? ar_req_t'{m1_addr, m1_len, m1_size}
                             : ar_req_t'{m0_addr, m0_len, m0_size};
            end
        end
    end

    assign arvalid = (state == ADDR);
    assign arid    = {{(ID_W-1){1'b0}}, owner};
    assign araddr  = ar_q.addr;
    assign arlen   = ar_q.len;
    assign arsize  = ar_q.size;
    assign arburst = 2'b01;
    assign arlock  = 1'b0;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    assign m0_gnt = ar_hs & ~owner;
    assign m1_gnt = ar_hs &  owner;

    // Routing follows the owner register; rid is irrelevant with a single burst in flight.
    assign rready    = (state == DATA) & (owner ? m1_rready : m0_rready);
    assign m0_rvalid = (state == DATA) & rvalid & ~owner;
    assign m1_rvalid = (state == DATA) & rvalid &  owner;
    assign m0_rlast  = m0_rvalid & rlast;
    assign m1_rlast  = m1_rvalid & rlast;
    assign m0_rdata  = rdata;
    assign m1_rdata  = rdata;

    logic unused_r;
    assign unused_r = ^{rid, rresp};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: reset, single burst, ties, R backpressure, AR stall, mid-burst reset.
// Tie expectations follow the AXI_RD_ARB_RR_EN build option.
module tb_axi_rd_arbiter;

    logic        aclk = 1'b0;
    logic        global_reset;
    logic        m0_req, m1_req, m0_rready, m1_rready;
    logic [31:0] m0_addr, m1_addr;
    logic [7:0]  m0_len, m1_len;
    logic [2:0]  m0_size, m1_size;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
    logic [31:0] m0_rdata, m1_rdata;
    logic [3:0]  arid, rid;
    logic [31:0] araddr, rdata;
    logic [7:0]  arlen;
    logic [2:0]  arsize, arprot;
    logic [1:0]  arburst, rresp;
    logic        arlock, arvalid, arready, rlast, rvalid, rready;
    logic [3:0]  arcache;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axi_rd_arbiter #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .global_reset(global_reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_len(m0_len), .m0_size(m0_size),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rlast(m0_rlast),
        .m0_rready(m0_rready),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_len(m1_len), .m1_size(m1_size),
        .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rlast(m1_rlast),
        .m1_rready(m1_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    // Slave-side stimulus: wait for AR, accept it, then return nb beats with requester rready high.
    // drop: 0 keep reqs, 1 drop the granted req, 2 drop both reqs.
    task automatic serve(input int nb, input logic [31:0] base, input int drop,
                         output logic g0, output logic g1, output logic [3:0] id, output bit ok);
        ok = 1'b0; g0 = 1'b0; g1 = 1'b0; id = 4'hx;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (arvalid === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        arready = 1'b1;
        #1 g0 = m0_gnt; g1 = m1_gnt; id = arid;
        @(negedge aclk);
        arready = 1'b0;
        if (drop == 2) begin m0_req = 1'b0; m1_req = 1'b0; end
        else if (drop == 1) begin
            if (g0) m0_req = 1'b0;
            if (g1) m1_req = 1'b0;
        end
        for (int i = 0; i < nb; i++) begin
            rvalid = 1'b1; rdata = base + 32'(i); rlast = (i == nb - 1);
            @(negedge aclk);
        end
        rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_reset();
        global_reset = 1'b1;
        repeat (3) @(negedge aclk);
        n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got %b want 0", arvalid); end
        n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL rst_rready got %b want 0", rready); end
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b00) begin n_fail++; $display("FAIL rst_gnt got %b want 00", {m0_gnt, m1_gnt}); end
        rvalid = 1'b1;
        #1;
        n_checks++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_rvalid got %b want 00", {m0_rvalid, m1_rvalid}); end
        n_checks++; if (arid !== 4'h0) begin n_fail++; $display("FAIL rst_owner arid got %h want 0", arid); end
        rvalid = 1'b0;
        @(negedge aclk);
        global_reset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_single();
        m0_req = 1'b1; m0_addr = 32'h1C00_0000; m0_len = 8'd3; m0_size = 3'd2;
        @(negedge aclk);
        n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL single_latency arvalid got %b want 1", arvalid); end
        n_checks++; if (araddr !== 32'h1C00_0000) begin n_fail++; $display("FAIL single_araddr got %h want 1c000000", araddr); end
        n_checks++; if (arid !== 4'h0) begin n_fail++; $display("FAIL single_arid got %h want 0", arid); end
        n_checks++; if (arlen !== 8'd3 || arsize !== 3'd2) begin n_fail++; $display("FAIL single_len_size got %0d/%0d want 3/2", arlen, arsize); end
        n_checks++; if ({arburst, arlock, arcache, arprot} !== {2'b01, 1'b0, 4'h0, 3'h0}) begin
            n_fail++; $display("FAIL single_fixed got %b/%b/%h/%h want 01/0/0/0", arburst, arlock, arcache, arprot); end
        n_checks++; if (m0_gnt !== 1'b0) begin n_fail++; $display("FAIL single_early_gnt got %b want 0", m0_gnt); end
        repeat (2) @(negedge aclk);
        n_checks++; if (arvalid !== 1'b1) begin n_fail++; $display("FAIL single_hold arvalid got %b want 1", arvalid); end
        arready = 1'b1;
        #1;
        n_checks++; if ({m0_gnt, m1_gnt} !== 2'b10) begin n_fail++; $display("FAIL single_gnt got %b want 10", {m0_gnt, m1_gnt}); end
        @(negedge aclk);
        arready = 1'b0; m0_req = 1'b0;
        n_checks++; if (m0_gnt !== 1'b0 || arvalid !== 1'b0) begin n_fail++; $display("FAIL single_gnt_pulse gnt %b arvalid %b want 0 0", m0_gnt, arvalid); end
        for (int i = 0; i < 4; i++) begin
            rvalid = 1'b1; rdata = 32'hA000_0000 + 32'(i); rlast = (i == 3);
            #1;
            n_checks++;
            if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || rready !== 1'b1 ||
                m0_rdata !== 32'hA000_0000 + 32'(i) || m0_rlast !== (i == 3)) begin
                n_fail++;
                $display("FAIL single_beat%0d got rv0 %b rv1 %b rr %b d %h last %b", i, m0_rvalid, m1_rvalid, rready, m0_rdata, m0_rlast);
            end
            @(negedge aclk);
        end
        rvalid = 1'b0; rlast = 1'b0;
        #1;
        n_checks++; if (rready !== 1'b0 || arvalid !== 1'b0) begin n_fail++; $display("FAIL single_done rready %b arvalid %b want 0 0", rready, arvalid); end
        @(negedge aclk);
    endtask

    task automatic test_tie();
        logic g0, g1;
        logic [3:0] id;
        bit ok;
        logic exp1;
        @(negedge aclk); global_reset = 1'b1;
        @(negedge aclk); global_reset = 1'b0;
        m0_addr = 32'h0000_1000; m0_len = 8'd0; m1_addr = 32'h0000_2000; m1_len = 8'd0;
        // Both raise together, both are served, three rounds.
        for (int r = 0; r < 3; r++) begin
            m0_req = 1'b1; m1_req = 1'b1;
            for (int s = 0; s < 2; s++) begin
`ifdef AXI_RD_ARB_RR_EN
                exp1 = (s == 1);
`else
                exp1 = (s == 0);
`endif
                serve(1, 32'h0, 1, g0, g1, id, ok);
                n_checks++;
                if (!ok || g1 !== exp1 || g0 !== ~exp1 || id !== {3'b0, exp1}) begin
                    n_fail++;
                    $display("FAIL tie_round%0d_%0d ok %0d gnt %b%b arid %h want m1=%b", r, s, ok, g1, g0, id, exp1);
                end
            end
        end
        // Both requesters keep asking back to back.
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef AXI_RD_ARB_RR_EN
            exp1 = (k % 2 == 1);
`else
            exp1 = 1'b1;
`endif
            serve(1, 32'h0, (k == 3) ? 2 : 0, g0, g1, id, ok);
            n_checks++;
            if (!ok || g1 !== exp1 || g0 !== ~exp1) begin
                n_fail++;
                $display("FAIL tie_cont%0d ok %0d gnt m1 %b m0 %b want m1=%b", k, ok, g1, g0, exp1);
            end
        end
        @(negedge aclk);
    endtask

    task automatic test_rready_toggle();
        logic g0, g1;
        logic [3:0] id;
        bit ok;
        logic [31:0] dat [3];
        logic [31:0] got [3];
        logic pat [5];
        int idx, n;
        dat = '{32'hDEAD_0001, 32'hBEEF_0002, 32'hCAFE_0003};
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        idx = 0; n = 0;
        m1_req = 1'b1; m1_addr = 32'h0000_3000; m1_len = 8'd2;
        serve(0, 32'h0, 1, g0, g1, id, ok);
        n_checks++; if (!ok || g1 !== 1'b1) begin n_fail++; $display("FAIL bp_gnt ok %0d m1_gnt %b want 1", ok, g1); end
        for (int c = 0; c < 5; c++) begin
            m1_rready = pat[c]; rvalid = 1'b1; rdata = dat[idx]; rlast = (idx == 2);
            #1;
            n_checks++;
            if (rready !== pat[c] || m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL bp_cycle%0d rready %b want %b rv1 %b rv0 %b", c, rready, pat[c], m1_rvalid, m0_rvalid);
            end
            if (m1_rvalid && rready && n < 3) begin got[n] = m1_rdata; n++; end
            @(negedge aclk);
            if (pat[c]) idx++;
            if (idx == 3) break;
        end
        rvalid = 1'b0; rlast = 1'b0; m1_rready = 1'b1;
        n_checks++; if (n !== 3) begin n_fail++; $display("FAIL bp_count got %0d want 3", n); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (got[i] !== dat[i]) begin n_fail++; $display("FAIL bp_order%0d got %h want %h", i, got[i], dat[i]); end
        end
        #1;
        n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL bp_done rready %b want 0", rready); end
        @(negedge aclk);
    endtask

    task automatic test_ar_stall();
        bit seen;
        seen = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h8000_0040; m0_len = 8'd7; m0_size = 3'd2;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            if (arvalid === 1'b1) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL stall_arvalid timeout"); end
        for (int c = 0; c < 20; c++) begin
            m1_req = c[0]; m1_addr = 32'(c) * 32'h10; m1_len = 8'(c);
            @(negedge aclk);
            n_checks++;
            if (arvalid !== 1'b1 || araddr !== 32'h8000_0040 || arlen !== 8'd7 || arid !== 4'h0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d arvalid %b araddr %h arlen %0d arid %h gnt %b%b", c, arvalid, araddr, arlen, arid, m1_gnt, m0_gnt);
            end
        end
        m1_req = 1'b0;
        arready = 1'b1;
        #1;
        n_checks++; if ({m1_gnt, m0_gnt} !== 2'b01) begin n_fail++; $display("FAIL stall_gnt got %b%b want 01", m1_gnt, m0_gnt); end
        @(negedge aclk);
        arready = 1'b0; m0_req = 1'b0;
        rvalid = 1'b1; rdata = 32'h1234_5678; rlast = 1'b1;
        @(negedge aclk);
        rvalid = 1'b0; rlast = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_reset_mid();
        logic g0, g1;
        logic [3:0] id;
        bit ok;
        m0_req = 1'b1; m0_addr = 32'h1C00_0100; m0_len = 8'd3;
        serve(0, 32'h0, 1, g0, g1, id, ok);
        n_checks++; if (!ok || g0 !== 1'b1) begin n_fail++; $display("FAIL mid_gnt ok %0d m0_gnt %b want 1", ok, g0); end
        rvalid = 1'b1; rdata = 32'h0000_0B01; rlast = 1'b0;
        @(negedge aclk);
        rdata = 32'h0000_0B02;
        #1;
        n_checks++; if (m0_rvalid !== 1'b1) begin n_fail++; $display("FAIL mid_beat2 m0_rvalid %b want 1", m0_rvalid); end
        global_reset = 1'b1;
        @(negedge aclk);
        n_checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0 || m0_gnt !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset arvalid %b rready %b rv %b%b gnt %b want all 0", arvalid, rready, m1_rvalid, m0_rvalid, m0_gnt);
        end
        global_reset = 1'b0; rvalid = 1'b0;
        @(negedge aclk);
        n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL mid_idle arvalid %b want 0", arvalid); end
        m0_req = 1'b1; m0_addr = 32'h1C00_0200; m0_len = 8'd0;
        serve(1, 32'h0000_0C00, 1, g0, g1, id, ok);
        n_checks++;
        if (!ok || {g1, g0} !== 2'b01 || id !== 4'h0) begin
            n_fail++; $display("FAIL mid_regrant ok %0d gnt %b%b arid %h want 01 / 0", ok, g1, g0, id);
        end
        @(negedge aclk);
    endtask

    initial begin
        global_reset = 1'b1;
        m0_req = 1'b0; m0_addr = '0; m0_len = '0; m0_size = 3'd2; m0_rready = 1'b1;
        m1_req = 1'b0; m1_addr = '0; m1_len = '0; m1_size = 3'd2; m1_rready = 1'b1;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        test_reset();
        test_single();
        test_tie();
        test_rready_toggle();
        test_ar_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
